// File: rtl/sample_tick_sequencer_pkg.sv
//------------------------------------------------------------------------------
//  Module   : sample_tick_pkg
//  Purpose  : Shared constants for the sample tick sequencer: operating mode
//             codes, FSM state encoding and small mode-decode helpers.
//  Contents : MODE_SINGLE / MODE_BURST / MODE_CONT, ST_IDLE / ST_RUN,
//             mode_is_burst(), mode_is_cont()
//  Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sample_tick_pkg;

   // Operating modes as presented on i_mode. Code 2'b11 is reserved and is
   // decoded exactly like MODE_SINGLE.
   localparam logic [1:0] MODE_SINGLE = 2'b00;
   localparam logic [1:0] MODE_BURST  = 2'b01;
   localparam logic [1:0] MODE_CONT   = 2'b10;

   // Two-state sequencer: waiting for a start, or generating ticks.
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   function automatic logic mode_is_burst(input logic [1:0] mode);
      return (mode == MODE_BURST);
   endfunction

   function automatic logic mode_is_cont(input logic [1:0] mode);
      return (mode == MODE_CONT);
   endfunction

endpackage : sample_tick_pkg

`default_nettype wire

// File: rtl/sample_tick_sequencer_if.sv
//------------------------------------------------------------------------------
//  Module   : sample_tick_sequencer_if
//  Purpose  : Control/status bundle between the chirp control FSM (master)
//             and the sample tick sequencer (slave).
//  Signals  : i_start_n   active-low start request (falling edge starts)
//             i_stop_n    active-low level abort
//             i_mode      00 single, 01 burst, 10 continuous, 11 = single
//             i_div_m1    tick period minus one, in clocks
//             i_num_ticks burst length (0 treated as 1)
//             o_sample_tick_n active-low 1-cycle tick
//             o_busy      high while running
//             o_done      1-cycle pulse on natural completion
//             o_tick_idx  ticks issued since the last accepted start
//  Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sample_tick_sequencer_if #(
   parameter int DIV_W = 8,
   parameter int CNT_W = 10
);

   logic             i_start_n;
   logic             i_stop_n;
   logic [1:0]       i_mode;
   logic [DIV_W-1:0] i_div_m1;
   logic [CNT_W-1:0] i_num_ticks;

   logic             o_sample_tick_n;
   logic             o_busy;
   logic             o_done;
   logic [CNT_W-1:0] o_tick_idx;

   // Controller side: issues requests, observes ticks and status.
   modport master (
      output i_start_n,
      output i_stop_n,
      output i_mode,
      output i_div_m1,
      output i_num_ticks,
      input  o_sample_tick_n,
      input  o_busy,
      input  o_done,
      input  o_tick_idx
   );

   // Sequencer side.
   modport slave (
      input  i_start_n,
      input  i_stop_n,
      input  i_mode,
      input  i_div_m1,
      input  i_num_ticks,
      output o_sample_tick_n,
      output o_busy,
      output o_done,
      output o_tick_idx
   );

endinterface : sample_tick_sequencer_if

`default_nettype wire

// File: rtl/sample_tick_sequencer_tick_period_counter.sv
//------------------------------------------------------------------------------
//  Module   : tick_period_counter
//  Purpose  : Free-running period counter 0..div_m1 with a combinational wrap
//             flag, used to pace sample ticks.
//  Ports    : i_clk, i_rst_n  clock / synchronous active-low reset
//             i_clr           force count to zero (priority over i_en)
//             i_en            advance the count this cycle
//             i_div_m1        terminal count (period minus one)
//             o_wrap          high when enabled and count == i_div_m1
//  Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tick_period_counter #(
   parameter int DIV_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [DIV_W-1:0] i_div_m1,
   output logic             o_wrap
);

   logic [DIV_W-1:0] r_count;
   logic             w_at_top;

   assign w_at_top = (r_count == i_div_m1);

   // The wrap flag is gated by the enable so that a cycle where the owner
   // holds the counter (e.g. during an abort) can never produce a tick.
   assign o_wrap = i_en & w_at_top;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= w_at_top ? '0 : (r_count + 1'b1);
      end
   end

endmodule : tick_period_counter

`default_nettype wire

// File: rtl/sample_tick_sequencer.sv
//------------------------------------------------------------------------------
//  Module   : sample_tick_sequencer
//  Purpose  : Generates active-low, 1-cycle sample ticks at a programmable
//             period in single, burst-of-N or continuous mode. A start is a
//             falling edge on i_start_n; i_stop_n aborts. Mode, period and
//             burst length are captured at start and held for the whole run.
//  Ports    : i_clk, i_rst_n  clock / synchronous active-low reset
//             bus             sample_tick_sequencer_if.slave (requests in,
//                             tick / busy / done / tick index out)
//  Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sample_tick_sequencer
   import sample_tick_pkg::*;
#(
   parameter int DIV_W = 8,
   parameter int CNT_W = 10
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   sample_tick_sequencer_if.slave  bus
);

   localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

   // Sequencer state and captured run configuration
   logic [0:0]       r_state;
   logic             r_prev_start_n;
   logic [1:0]       r_mode;
   logic [DIV_W-1:0] r_div_m1;
   logic [CNT_W-1:0] r_num_eff;

   // Registered outputs
   logic             r_tick_n;
   logic             r_busy;
   logic             r_done;
   logic [CNT_W-1:0] r_tick_idx;

   logic             w_start_evt;
   logic             w_accept;
   logic             w_cnt_en;
   logic             w_wrap;
   logic [CNT_W-1:0] w_idx_next;
   logic             w_last;

   // The history register resets to 0, so a start input already low when
   // reset is released is not seen as an edge: it must go high first.
   assign w_start_evt = r_prev_start_n & ~bus.i_start_n;

   // A start coinciding with an abort is discarded.
   assign w_accept = (r_state == ST_IDLE) & w_start_evt & bus.i_stop_n;

   // The counter only advances while running and not being aborted, so an
   // abort landing on the terminal count suppresses that tick.
   assign w_cnt_en = (r_state == ST_RUN) & bus.i_stop_n;

   assign w_idx_next = r_tick_idx + 1'b1;

   // Whether the tick about to be issued ends the run. Reserved mode 2'b11
   // falls through to the single-shot case.
   always_comb begin
      w_last = 1'b1;
      if (mode_is_cont(r_mode)) begin
         w_last = 1'b0;
      end else if (mode_is_burst(r_mode)) begin
         w_last = (w_idx_next == r_num_eff);
      end
   end

   tick_period_counter #(
      .DIV_W (DIV_W)
   ) u_period (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clr    (w_accept),
      .i_en     (w_cnt_en),
      .i_div_m1 (r_div_m1),
      .o_wrap   (w_wrap)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state        <= ST_IDLE;
         r_prev_start_n <= 1'b0;
         r_mode         <= MODE_SINGLE;
         r_div_m1       <= '0;
         r_num_eff      <= c_one;
         r_tick_n       <= 1'b1;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_tick_idx     <= '0;
      end else begin
         r_prev_start_n <= bus.i_start_n;
         // Tick and done are single-cycle pulses unless set below.
         r_tick_n       <= 1'b1;
         r_done         <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_mode     <= bus.i_mode;
                  r_div_m1   <= bus.i_div_m1;
                  r_num_eff  <= (bus.i_num_ticks == '0) ? c_one : bus.i_num_ticks;
                  r_tick_idx <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_RUN;
               end
            end

            ST_RUN: begin
               if (!bus.i_stop_n) begin
                  // Abort: no tick, no done, tick index is preserved.
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (w_wrap) begin
                  r_tick_n   <= 1'b0;
                  r_tick_idx <= w_idx_next;
                  if (w_last) begin
                     // Busy drops and done pulses in the same cycle as the
                     // final tick; IDLE is entered so a start in the very
                     // next cycle is accepted.
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= ST_IDLE;
                  end
               end
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.o_sample_tick_n = r_tick_n;
   assign bus.o_busy          = r_busy;
   assign bus.o_done          = r_done;
   assign bus.o_tick_idx      = r_tick_idx;

endmodule : sample_tick_sequencer

`default_nettype wire

// File: tb/tb_sample_tick_sequencer.sv
//------------------------------------------------------------------------------
//  Module   : tb_sample_tick_sequencer
//  Purpose  : Self-checking bench for sample_tick_sequencer. Directed
//             scenarios push the expected tick events (cycle, index, done)
//             into a scoreboard queue; a monitor pops and compares on every
//             observed low tick and flags stray ticks or done pulses.
//  Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sample_tick_sequencer;
   import sample_tick_pkg::*;

   localparam int DIV_W = 8;
   localparam int CNT_W = 4;

   typedef struct {
      int               cyc;
      logic [CNT_W-1:0] idx;
      logic             done;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   exp_t mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sample_tick_sequencer_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

   sample_tick_sequencer #(
      .DIV_W (DIV_W),
      .CNT_W (CNT_W)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Monitor: every low tick must match the head of the scoreboard.
   always @(negedge clk) begin
      if (bus.o_sample_tick_n === 1'b0) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tick: tick low at cycle %0d, expected none", cyc);
         end else begin
            mon_e = sb.pop_front();
            check("tick_cycle", cyc, mon_e.cyc);
            check("tick_idx", int'(bus.o_tick_idx), int'(mon_e.idx));
            check("tick_done", int'(bus.o_done), int'(mon_e.done));
            check("tick_busy", int'(bus.o_busy), int'(!mon_e.done));
         end
      end else if (bus.o_done !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL done_without_tick: o_done got %b expected 0 at cycle %0d", bus.o_done, cyc);
      end
   end

   // Advance n clock edges, landing 1 time unit after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Falling start edge presented in the current cycle t; released next cycle.
   task automatic start(output int t);
      bus.i_start_n = 1'b0;
      t = cyc;
      step(1);
      bus.i_start_n = 1'b1;
   endtask

   // Tick k (1..n) is low at cycle t + 1 + k*p.
   task automatic expect_ticks(input int t, input int p, input int n, input bit done_at_end);
      exp_t e;
      for (int k = 1; k <= n; k++) begin
         e.cyc  = t + 1 + k * p;
         e.idx  = CNT_W'(k);
         e.done = done_at_end && (k == n);
         sb.push_back(e);
      end
   endtask

   task automatic drain(input int limit);
      int i;
      i = 0;
      while (sb.size() != 0 && i < limit) begin
         step(1);
         i++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d ticks still pending, required 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int t2;

      bus.i_start_n   = 1'b0;
      bus.i_stop_n    = 1'b1;
      bus.i_mode      = MODE_SINGLE;
      bus.i_div_m1    = 8'd79;
      bus.i_num_ticks = 4'd1;

      // Reset with start held low
      step(3);
      check("rst_tick_n", int'(bus.o_sample_tick_n), 1);
      check("rst_busy", int'(bus.o_busy), 0);
      check("rst_done", int'(bus.o_done), 0);
      check("rst_idx", int'(bus.o_tick_idx), 0);
      rst_n = 1'b1;
      step(5);
      check("held_low_no_start", int'(bus.o_busy), 0);
      bus.i_start_n = 1'b1;
      step(1);

      // Single, div_m1=79: one tick at T+81
      start(t);
      expect_ticks(t, 80, 1, 1'b1);
      check("single_busy_T1", int'(bus.o_busy), 1);
      step(79);
      check("single_busy_T80", int'(bus.o_busy), 1);
      drain(50);
      step(10);
      check("single_idx", int'(bus.o_tick_idx), 1);
      check("single_idle", int'(bus.o_busy), 0);

      // Burst of 5, div_m1=19, with a second start edge and config changes mid-run
      bus.i_mode      = MODE_BURST;
      bus.i_div_m1    = 8'd19;
      bus.i_num_ticks = 4'd5;
      start(t);
      expect_ticks(t, 20, 5, 1'b1);
      step(28);
      bus.i_start_n = 1'b0;
      step(1);
      bus.i_start_n = 1'b1;
      step(20);
      bus.i_div_m1    = 8'd3;
      bus.i_num_ticks = 4'd2;
      bus.i_mode      = MODE_CONT;
      drain(150);
      step(30);
      check("burst_idx", int'(bus.o_tick_idx), 5);
      check("burst_idle", int'(bus.o_busy), 0);

      // Continuous, div_m1=0: index wraps 15->0; stop lands on a wrap cycle
      bus.i_mode   = MODE_CONT;
      bus.i_div_m1 = 8'd0;
      start(t);
      expect_ticks(t, 1, 19, 1'b0);
      step(19);
      bus.i_stop_n = 1'b0;
      step(1);
      check("cont_stop_busy", int'(bus.o_busy), 0);
      check("cont_stop_tick", int'(bus.o_sample_tick_n), 1);
      bus.i_stop_n = 1'b1;
      drain(10);
      step(10);
      check("cont_idx", int'(bus.o_tick_idx), 3);

      // Abort coinciding with terminal count, div_m1=39
      bus.i_mode      = MODE_BURST;
      bus.i_div_m1    = 8'd39;
      bus.i_num_ticks = 4'd3;
      start(t);
      expect_ticks(t, 40, 1, 1'b0);
      step(79);
      bus.i_stop_n = 1'b0;
      step(1);
      check("abort_busy", int'(bus.o_busy), 0);
      bus.i_stop_n = 1'b1;
      step(20);
      check("abort_idx", int'(bus.o_tick_idx), 1);

      // Start and stop in the same IDLE cycle
      bus.i_stop_n  = 1'b0;
      bus.i_start_n = 1'b0;
      step(1);
      bus.i_start_n = 1'b1;
      bus.i_stop_n  = 1'b1;
      step(5);
      check("start_stop_idle", int'(bus.o_busy), 0);
      check("start_stop_idx", int'(bus.o_tick_idx), 1);

      // Burst with num_ticks=0 (one tick), restarted on the done cycle
      bus.i_div_m1    = 8'd3;
      bus.i_num_ticks = 4'd0;
      start(t);
      expect_ticks(t, 4, 1, 1'b1);
      step(4);
      start(t2);
      check("restart_cycle", t2, t + 5);
      expect_ticks(t2, 4, 1, 1'b1);
      drain(30);
      step(5);
      check("num0_idle", int'(bus.o_busy), 0);

      // Reset mid-run
      bus.i_mode   = MODE_CONT;
      bus.i_div_m1 = 8'd9;
      start(t);
      expect_ticks(t, 10, 2, 1'b0);
      step(24);
      rst_n = 1'b0;
      step(1);
      check("midrst_tick_n", int'(bus.o_sample_tick_n), 1);
      check("midrst_busy", int'(bus.o_busy), 0);
      check("midrst_idx", int'(bus.o_tick_idx), 0);
      rst_n = 1'b1;
      drain(5);
      step(30);
      check("post_rst_idle", int'(bus.o_busy), 0);

      check("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_sample_tick_sequencer

`default_nettype wire

// File: doc/sample_tick_sequencer.md
Name: sample_tick_sequencer

Overview:
Parametrised successor to the fixed-preset sample tick generator. Produces active-low, 1-cycle sample ticks at a runtime-programmable period, in three modes: single, burst of N, and continuous. Adds start edge detection, abort, busy/done status and a tick index. Sits between the chirp control FSM and the sampling/DSP front end.

Parameters:
DIV_W, 8, width of the period-minus-one value; period range 1..2^DIV_W clocks
CNT_W, 10, width of the burst length and the tick index

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset
i_start_n  in  1  active-low start request; a start is a 1->0 transition
i_stop_n  in  1  active-low abort, level-sensitive
i_mode  in  2  00 single, 01 burst, 10 continuous, 11 reserved (behaves as single)
i_div_m1  in  DIV_W  tick period minus one, in clocks
i_num_ticks  in  CNT_W  burst length; 0 is treated as 1
o_sample_tick_n  out  1  active-low, 1-cycle sample tick
o_busy  out  1  high while in RUN
o_done  out  1  1-cycle high pulse on natural completion
o_tick_idx  out  CNT_W  number of ticks issued since the last start

Behaviour:
- Reset is synchronous and active-low on i_rst_n; clock is i_clk.
- Reset values: o_sample_tick_n=1, o_busy=0, o_done=0, o_tick_idx=0, state=IDLE, counter=0, start-history register=0.
- Start-history reset value 0: i_start_n held low through reset does not start. It must go high, then low.
- Start edge: start_evt = (prev_start_n==1 && i_start_n==0). prev_start_n is registered every cycle.
- States: IDLE, RUN. All outputs are registered.
- IDLE:
  - o_sample_tick_n=1.
  - On start_evt with i_stop_n=1: latch i_mode, i_div_m1 and i_num_ticks; clear counter and o_tick_idx; go to RUN.
  - o_busy=1 from the next cycle.
- RUN:
  - Counter increments 0..div_m1.
  - When counter==div_m1: counter<=0, o_sample_tick_n<=0 for one cycle, o_tick_idx<=o_tick_idx+1.
  - Otherwise o_sample_tick_n<=1.
- Latency: start_evt sampled at cycle T, so RUN begins at T+1 with counter=0. First tick is low in cycle T+1+P, where P=div_m1+1. Later ticks follow every P cycles.
- div_m1=0: a tick every cycle, starting at T+2.
- Single mode: after 1 tick, go to IDLE.
- Burst mode: after num_ticks ticks, go to IDLE.
- Completion:
  - o_done=1 in the same cycle the last tick is low.
  - o_busy=0 in that same cycle.
- Continuous mode:
  - Runs until i_stop_n=0; o_done is never pulsed.
  - o_tick_idx wraps from 2^CNT_W-1 to 0 modulo 2^CNT_W.
- Abort: i_stop_n=0 sampled in RUN.
  - Next cycle: IDLE, o_busy=0, no tick, no o_done.
  - o_tick_idx holds its value.
  - If this coincides with counter==div_m1, stop wins and no tick is issued.
- start_evt and i_stop_n=0 in the same IDLE cycle: stay IDLE.
- start_evt during RUN is ignored; it does not restart or re-latch.
- Restart: a new start_evt in the cycle right after completion is accepted (IDLE is entered on the done cycle).
- Changes to i_div_m1, i_mode or i_num_ticks during RUN have no effect, because the values were latched at start.
- Reset mid-RUN forces all reset values on the next edge.
- Arithmetic: counter is DIV_W bits unsigned. Burst compare is (o_tick_idx+1)==num_eff at tick time, with num_eff = (num_ticks==0)?1:num_ticks, all at CNT_W bits.

Decomposition:
- Package sample_tick_pkg holds:
  - mode constants MODE_SINGLE=2'b00, MODE_BURST=2'b01, MODE_CONT=2'b10;
  - state encoding ST_IDLE, ST_RUN.
- One sub-module, tick_period_counter (params DIV_W):
  - inputs i_clk, i_rst_n, i_clr, i_en, i_div_m1;
  - output o_wrap, combinational, high when count==div_m1 and i_en=1.
- The top level holds the edge detect, FSM, burst count and outputs.

Test Plan:
- Single, div_m1=79, start falling at T -> exactly one low tick at T+81, o_done=1 at T+81, o_busy high T+1..T+80, o_tick_idx=1.
- Burst, div_m1=19, num_ticks=5 -> ticks at T+21, T+41, T+61, T+81, T+101; o_done only at T+101; o_tick_idx=5; no sixth tick.
- Continuous, div_m1=0, CNT_W=4 -> tick every cycle from T+2; o_tick_idx wraps 15->0; i_stop_n=0 at cycle S -> o_busy=0 at S+1, no tick at S+1 onward, o_done never high.
- Abort coinciding with counter==div_m1 (div_m1=39) -> no tick that period; o_tick_idx unchanged. Also: start plus stop in the same IDLE cycle -> remains IDLE.
- i_start_n held low through and after reset -> no start; then high 1 cycle and low -> starts. A second falling edge mid-burst -> ignored, and tick timing is unchanged.
- Burst with num_ticks=0, div_m1=3 -> one tick at T+5 with o_done. Changing i_div_m1 mid-run -> period unchanged. Reset asserted mid-RUN -> o_sample_tick_n=1, o_busy=0, o_tick_idx=0 next cycle.
